// File: rtl/frame_rx_checker.sv
// frame_rx_checker: strips preamble/SFD from a byte stream, forwards the frame
// body without its FCS, checks CRC32 and length, and counts good/bad frames.
module frame_rx_checker #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rxd,
    input  logic             rx_dv,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 11;
    localparam int unsigned DLY_N  = 5;
    localparam int unsigned PRE_W  = 3;
    localparam int unsigned PRE_N  = 7;

    localparam logic [LEN_W-1:0]  LEN_SAT  = '1;
    localparam logic [BYTE_W-1:0] PRE_BYTE = 8'h55;
    localparam logic [BYTE_W-1:0] SFD_BYTE = 8'hD5;
    localparam logic [31:0]       CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0]       CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]       CRC_XOR  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PRE  = 2'd2,
        ST_BODY = 2'd3
    } state_t;

    state_t                           state;
    logic [PRE_W-1:0]                 pre_cnt;
    logic [LEN_W-1:0]                 len;
    logic [DLY_N-1:0][BYTE_W-1:0]     dly;
    logic [31:0]                      crc;

    logic [31:0]                      crc_fin_c;
    logic [31:0]                      fcs_c;
    logic                             have_beat_c;
    logic                             first_beat_c;
    logic                             frame_err_c;

    // Reflected CRC32 update, one byte, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [BYTE_W-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (r[0] ^ d[i]) begin
                r = (r >> 1) ^ CRC_POLY;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    // End-of-frame verdict: last body byte folded into the CRC, FCS taken from the 4 youngest bytes.
    always_comb begin
        crc_fin_c    = crc_next(crc, dly[DLY_N-1]) ^ CRC_XOR;
        fcs_c        = {dly[0], dly[1], dly[2], dly[3]};
        have_beat_c  = (len >= LEN_W'(DLY_N));
        first_beat_c = (len == LEN_W'(DLY_N));
        frame_err_c  = !have_beat_c
                     || (len < LEN_W'(MIN_LEN))
                     || (len > LEN_W'(MAX_LEN))
                     || (crc_fin_c != fcs_c);
    end

    // Receive FSM, delay line, CRC, registered output beats and frame counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            pre_cnt   <= '0;
            len       <= '0;
            dly       <= '0;
            crc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_err   <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_err   <= 1'b0;

            case (state)
                ST_WAIT: begin
                    if (!rx_dv) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (rx_dv) begin
                        if (rxd == PRE_BYTE) begin
                            state   <= ST_PRE;
                            pre_cnt <= PRE_W'(1);
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_PRE: begin
                    if (!rx_dv) begin
                        state <= ST_IDLE;
                    end else if (rxd == PRE_BYTE) begin
                        if (pre_cnt == PRE_W'(PRE_N)) begin
                            state <= ST_WAIT;
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                    end else if ((rxd == SFD_BYTE) && (pre_cnt == PRE_W'(PRE_N))) begin
                        state <= ST_BODY;
                        len   <= '0;
                        crc   <= CRC_INIT;
                    end else begin
                        state <= ST_WAIT;
                    end
                end

                ST_BODY: begin
                    if (rx_dv) begin
                        dly <= {dly[DLY_N-2:0], rxd};
                        if (len != LEN_SAT) begin
                            len <= len + LEN_W'(1);
                        end
                        if (have_beat_c) begin
                            out_valid <= 1'b1;
                            out_data  <= dly[DLY_N-1];
                            out_sop   <= first_beat_c;
                            crc       <= crc_next(crc, dly[DLY_N-1]);
                        end
                    end else begin
                        state <= ST_IDLE;
                        if (have_beat_c) begin
                            out_valid <= 1'b1;
                            out_data  <= dly[DLY_N-1];
                            out_sop   <= first_beat_c;
                            out_eop   <= 1'b1;
                            out_err   <= frame_err_c;
                        end
                        if (frame_err_c) begin
                            bad_cnt <= bad_cnt + CNT_W'(1);
                        end else begin
                            good_cnt <= good_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule
